// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP host driver: command opcodes,
// controller states and the word counts of one weight load / one inference.
package mlp_pkg;

   typedef enum logic {
      OpInit = 1'b0,
      OpRun  = 1'b1
   } op_e;

   typedef enum logic [2:0] {
      StIdle,
      StPrefill,
      StReq,
      StStream,
      StCollect,
      StDone
   } state_e;

   localparam logic [11:0] WordsW = 12'd2048;
   localparam logic [11:0] WordsX = 12'd256;

endpackage

// File: rtl/mlp_sync_fifo.sv
// Small synchronous prefetch FIFO with a show-ahead head word, full/empty
// flags and an occupancy count; push and pop may coincide even when full.
module mlp_sync_fifo #(
   parameter int DataWidth = 16,
   parameter int FifoDepth = 4
) (
   input  logic                         i_clk,
   input  logic                         i_clear,
   input  logic                         i_push,
   input  logic [DataWidth-1:0]         i_data,
   input  logic                         i_pop,
   output logic [DataWidth-1:0]         o_head,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(FifoDepth):0]   o_count
);

   localparam int AddrWidth = $clog2(FifoDepth);

   logic [DataWidth-1:0] r_mem [FifoDepth];
   logic [AddrWidth-1:0] r_wrPtr;
   logic [AddrWidth-1:0] r_rdPtr;
   logic [AddrWidth:0]   r_count;
   logic                 w_doPush;
   logic                 w_doPop;

   assign o_full   = (r_count == (AddrWidth+1)'(FifoDepth));
   assign o_empty  = (r_count == '0);
   assign w_doPop  = i_pop && !o_empty;
   assign w_doPush = i_push && (!o_full || w_doPop);
   assign o_head   = r_mem[r_rdPtr];
   assign o_count  = r_count;

   always_ff @(posedge i_clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_clear) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mlp_host_driver.sv
// Host-side initiator for the MLP core: prefetches upstream words, performs the
// init/start handshake, feeds one word per accelerator strobe and forwards results.
module mlp_host_driver
   import mlp_pkg::*;
#(
   parameter int DataWidth = 16,
   parameter int FifoDepth = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic                 cmd_op_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [DataWidth-1:0] in_data_i,
   output logic                 out_valid_o,
   output logic [DataWidth-1:0] out_data_o,
   output logic                 done_o,
   output logic                 err_o,
   input  logic                 err_clr_i,
   output logic                 init_valid_o,
   input  logic                 init_ready_i,
   output logic                 start_valid_o,
   input  logic                 start_ready_i,
   input  logic                 result_valid_i,
   input  logic                 w_wen_i,
   input  logic                 x_wen_i,
   input  logic                 x_sel_i,
   output logic [DataWidth-1:0] wdata_o,
   input  logic [DataWidth-1:0] rdata_i
);

   localparam int CountWidth = $clog2(FifoDepth) + 1;

   state_e               r_state;
   op_e                  r_op;
   logic [11:0]          r_count;
   logic                 r_err;
   logic                 r_outValid;
   logic [DataWidth-1:0] r_outData;

   logic                  w_inStream;
   logic                  w_strobe;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_underrun;
   logic                  w_inReady;
   logic                  w_fillNext;
   logic                  w_fifoClear;
   logic                  w_fifoFull;
   logic                  w_fifoEmpty;
   logic [DataWidth-1:0]  w_fifoHead;
   logic [CountWidth-1:0] w_fifoCount;
   logic [11:0]           w_countNext;
   logic                  w_handshake;

   assign w_inStream  = (r_state == StStream);
   assign w_strobe    = (r_op == OpInit) ? w_wen_i : (x_wen_i && !x_sel_i);
   assign w_pop       = w_inStream && w_strobe && !w_fifoEmpty;
   assign w_underrun  = w_inStream && w_strobe && w_fifoEmpty;
   assign w_push      = in_valid_i && w_inReady;
   assign w_fifoClear = rst_i || (r_state == StDone);
   assign w_countNext = r_count + 12'd1;
   assign w_handshake = (r_op == OpInit) ? init_ready_i : start_ready_i;

   // Leave Prefill on the edge that makes the FIFO full, so an always-ready
   // upstream spends exactly FifoDepth cycles here.
   assign w_fillNext = w_fifoFull ||
                       (w_push && (w_fifoCount == CountWidth'(FifoDepth - 1)));

   always_comb begin
      w_inReady = 1'b0;
      case (r_state)
         StPrefill: w_inReady = !w_fifoFull;
         StStream:  w_inReady = !w_fifoFull || w_pop;
         default:   w_inReady = 1'b0;
      endcase
   end

   mlp_sync_fifo #(
      .DataWidth(DataWidth),
      .FifoDepth(FifoDepth)
   ) u_fifo (
      .i_clk  (clk_i),
      .i_clear(w_fifoClear),
      .i_push (w_push),
      .i_data (in_data_i),
      .i_pop  (w_pop),
      .o_head (w_fifoHead),
      .o_full (w_fifoFull),
      .o_empty(w_fifoEmpty),
      .o_count(w_fifoCount)
   );

   assign cmd_ready_o   = (r_state == StIdle);
   assign in_ready_o    = w_inReady;
   assign init_valid_o  = (r_state == StReq) && (r_op == OpInit);
   assign start_valid_o = (r_state == StReq) && (r_op == OpRun);
   assign done_o        = (r_state == StDone);
   assign err_o         = r_err;
   assign out_valid_o   = r_outValid;
   assign out_data_o    = r_outData;
   assign wdata_o       = w_pop ? w_fifoHead : '0;

   // Collect stops counting at WordsX and spends one more cycle so done_o
   // lands the cycle after the last out_valid_o.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= StIdle;
         r_op       <= OpInit;
         r_count    <= '0;
         r_err      <= 1'b0;
         r_outValid <= 1'b0;
         r_outData  <= '0;
      end else begin
         r_outValid <= 1'b0;
         if (w_underrun) begin
            r_err <= 1'b1;
         end else if (err_clr_i) begin
            r_err <= 1'b0;
         end
         case (r_state)
            StIdle: begin
               if (cmd_valid_i) begin
                  r_op    <= op_e'(cmd_op_i);
                  r_state <= StPrefill;
               end
            end
            StPrefill: begin
               if (w_fillNext) begin
                  r_state <= StReq;
               end
            end
            StReq: begin
               if (w_handshake) begin
                  r_count <= '0;
                  r_state <= StStream;
               end
            end
            StStream: begin
               if (w_strobe) begin
                  r_count <= w_countNext;
                  if ((r_op == OpInit) && (w_countNext == WordsW)) begin
                     r_state <= StDone;
                  end else if ((r_op == OpRun) && (w_countNext == WordsX)) begin
                     r_count <= '0;
                     r_state <= StCollect;
                  end
               end
            end
            StCollect: begin
               if (r_count == WordsX) begin
                  r_state <= StDone;
               end else if (result_valid_i) begin
                  r_count    <= w_countNext;
                  r_outValid <= 1'b1;
                  r_outData  <= rdata_i;
               end
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mlp_host_driver.sv
// Directed bench for mlp_host_driver: drives a simple upstream source and an
// accelerator model cycle by cycle and checks outputs with immediate assertions.
module tb_mlp_host_driver;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_op_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [15:0] in_data_i;
   logic        out_valid_o;
   logic [15:0] out_data_o;
   logic        done_o;
   logic        err_o;
   logic        err_clr_i;
   logic        init_valid_o;
   logic        init_ready_i;
   logic        start_valid_o;
   logic        start_ready_i;
   logic        result_valid_i;
   logic        w_wen_i;
   logic        x_wen_i;
   logic        x_sel_i;
   logic [15:0] wdata_o;
   logic [15:0] rdata_i;

   int nAsserts = 0;
   int nFails   = 0;
   int upNext   = 0;
   int upLimit  = 1 << 20;
   logic upEnable = 1'b0;
   logic upFire   = 1'b0;

   mlp_host_driver #(.DataWidth(16), .FifoDepth(4)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .cmd_valid_i   (cmd_valid_i),
      .cmd_ready_o   (cmd_ready_o),
      .cmd_op_i      (cmd_op_i),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .in_data_i     (in_data_i),
      .out_valid_o   (out_valid_o),
      .out_data_o    (out_data_o),
      .done_o        (done_o),
      .err_o         (err_o),
      .err_clr_i     (err_clr_i),
      .init_valid_o  (init_valid_o),
      .init_ready_i  (init_ready_i),
      .start_valid_o (start_valid_o),
      .start_ready_i (start_ready_i),
      .result_valid_i(result_valid_i),
      .w_wen_i       (w_wen_i),
      .x_wen_i       (x_wen_i),
      .x_sel_i       (x_sel_i),
      .wdata_o       (wdata_o),
      .rdata_i       (rdata_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation did not finish");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive the upstream source, then let combinational outputs settle.
   task automatic applyStimulus();
      in_valid_i = upEnable && (upNext < upLimit);
      in_data_i  = upNext[15:0];
      #1;
      upFire = in_valid_i && in_ready_o;
   endtask

   task automatic advanceClock();
      @(posedge clk_i);
      #1;
      if (upFire) upNext++;
   endtask

   task automatic tick();
      applyStimulus();
      advanceClock();
   endtask

   task automatic resetDut();
      rst_i = 1'b1;
      cmd_valid_i = 1'b0; cmd_op_i = 1'b0; err_clr_i = 1'b0;
      init_ready_i = 1'b0; start_ready_i = 1'b0; result_valid_i = 1'b0;
      w_wen_i = 1'b0; x_wen_i = 1'b0; x_sel_i = 1'b0; rdata_i = '0;
      tick();
      rst_i = 1'b0;
   endtask

   task automatic startCmd(input logic op);
      cmd_valid_i = 1'b1;
      cmd_op_i    = op;
      applyStimulus();
      checkOutput("cmdReadyIdle", cmd_ready_o, 1);
      advanceClock();
      cmd_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         checkOutput("prefillInReady", in_ready_o, 1);
         checkOutput("prefillNoReq", init_valid_o | start_valid_o, 0);
         advanceClock();
      end
   endtask

   initial begin
      rst_i = 1'b1;
      resetDut();

      $display("[TB] reset state");
      applyStimulus();
      checkOutput("rstCmdReady", cmd_ready_o, 1);
      checkOutput("rstDone", done_o, 0);
      checkOutput("rstErr", err_o, 0);
      checkOutput("rstOutValid", out_valid_o, 0);
      checkOutput("rstOutData", out_data_o, 0);
      checkOutput("rstInitValid", init_valid_o, 0);
      checkOutput("rstStartValid", start_valid_o, 0);
      checkOutput("rstInReady", in_ready_o, 0);
      checkOutput("rstWdata", wdata_o, 0);
      advanceClock();

      $display("[TB] underrun during init");
      upEnable = 1'b1; upNext = 0; upLimit = 10;
      startCmd(1'b0);
      init_ready_i = 1'b1;
      applyStimulus();
      checkOutput("uInitValid", init_valid_o, 1);
      advanceClock();
      init_ready_i = 1'b0;
      w_wen_i = 1'b1;
      for (int k = 0; k < 10; k++) begin
         applyStimulus();
         checkOutput("uWdata", wdata_o, k);
         advanceClock();
      end
      applyStimulus();
      checkOutput("uStrobe11Wdata", wdata_o, 0);
      checkOutput("uErrBefore", err_o, 0);
      advanceClock();
      w_wen_i = 1'b0;
      applyStimulus();
      checkOutput("uErrSet", err_o, 1);
      advanceClock();
      w_wen_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         applyStimulus();
         checkOutput("uErrSticky", err_o, 1);
         advanceClock();
      end
      w_wen_i = 1'b0; err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      applyStimulus();
      checkOutput("uErrCleared", err_o, 0);
      advanceClock();
      w_wen_i = 1'b1; err_clr_i = 1'b1;
      tick();
      w_wen_i = 1'b0; err_clr_i = 1'b0;
      applyStimulus();
      checkOutput("uSetWins", err_o, 1);
      checkOutput("uNoDone", done_o, 0);
      advanceClock();
      resetDut();
      applyStimulus();
      checkOutput("uRstErr", err_o, 0);
      checkOutput("uRstCmdReady", cmd_ready_o, 1);
      advanceClock();

      $display("[TB] reset mid stream");
      upNext = 0; upLimit = 1 << 20;
      startCmd(1'b0);
      init_ready_i = 1'b1;
      tick();
      init_ready_i = 1'b0;
      w_wen_i = 1'b1;
      for (int k = 0; k < 100; k++) begin
         applyStimulus();
         checkOutput("mWdata", wdata_o, k);
         advanceClock();
      end
      resetDut();
      applyStimulus();
      checkOutput("mCmdReady", cmd_ready_o, 1);
      checkOutput("mNoDone", done_o, 0);
      checkOutput("mInReady", in_ready_o, 0);
      checkOutput("mWdataZero", wdata_o, 0);
      advanceClock();
      applyStimulus();
      checkOutput("mNoDoneLater", done_o, 0);
      advanceClock();

      $display("[TB] full init with handshake hold");
      upNext = 0;
      startCmd(1'b0);
      cmd_valid_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         applyStimulus();
         checkOutput("hInitValid", init_valid_o, 1);
         checkOutput("hCmdRefused", cmd_ready_o, 0);
         checkOutput("hNoPush", in_ready_o, 0);
         checkOutput("hNoPop", wdata_o, 0);
         advanceClock();
      end
      cmd_valid_i = 1'b0; init_ready_i = 1'b1;
      applyStimulus();
      checkOutput("hInitValidHs", init_valid_o, 1);
      advanceClock();
      init_ready_i = 1'b0;
      applyStimulus();
      checkOutput("hInitValidDrop", init_valid_o, 0);
      w_wen_i = 1'b1;
      for (int k = 0; k < 2048; k++) begin
         applyStimulus();
         checkOutput("iWdata", wdata_o, k);
         checkOutput("iNoDone", done_o, 0);
         advanceClock();
      end
      w_wen_i = 1'b0;
      upEnable = 1'b0;
      applyStimulus();
      checkOutput("iDone", done_o, 1);
      checkOutput("iErr", err_o, 0);
      advanceClock();
      applyStimulus();
      checkOutput("iDonePulse", done_o, 0);
      checkOutput("iIdle", cmd_ready_o, 1);
      advanceClock();

      $display("[TB] run end to end with internal strobes");
      upEnable = 1'b1; upNext = 0;
      startCmd(1'b1);
      start_ready_i = 1'b1;
      applyStimulus();
      checkOutput("rStartValid", start_valid_o, 1);
      checkOutput("rNoInitValid", init_valid_o, 0);
      advanceClock();
      start_ready_i = 1'b0;
      begin
         int ext = 0;
         int intn = 0;
         int cyc = 0;
         while (ext < 256) begin
            x_wen_i = 1'b1;
            if ((cyc % 6 == 5) && (intn < 50)) begin
               x_sel_i = 1'b1;
               intn++;
               tick();
            end else begin
               x_sel_i = 1'b0;
               applyStimulus();
               checkOutput("rWdata", wdata_o, ext);
               advanceClock();
               ext++;
            end
            cyc++;
         end
      end
      x_wen_i = 1'b0; x_sel_i = 1'b0;
      upEnable = 1'b0;
      for (int i = 0; i < 256; i++) begin
         result_valid_i = 1'b1;
         rdata_i = 16'h0100 + 16'(i);
         applyStimulus();
         if (i == 0) begin
            checkOutput("rCollectInReady", in_ready_o, 0);
            checkOutput("rFirstOutValid", out_valid_o, 0);
         end else begin
            checkOutput("rOutValid", out_valid_o, 1);
            checkOutput("rOutData", out_data_o, 32'h100 + 32'(i - 1));
            checkOutput("rNoDone", done_o, 0);
         end
         advanceClock();
      end
      result_valid_i = 1'b0;
      applyStimulus();
      checkOutput("rLastOutValid", out_valid_o, 1);
      checkOutput("rLastOutData", out_data_o, 32'h1FF);
      checkOutput("rDoneEarly", done_o, 0);
      advanceClock();
      applyStimulus();
      checkOutput("rDone", done_o, 1);
      checkOutput("rOutValidOff", out_valid_o, 0);
      advanceClock();
      applyStimulus();
      checkOutput("rDonePulse", done_o, 0);
      checkOutput("rIdle", cmd_ready_o, 1);
      checkOutput("rErr", err_o, 0);
      advanceClock();

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule

// File: doc/mlp_host_driver.md
# mlp_host_driver

Host-side initiator for the MLP accelerator controller. It accepts a command (load weights or run inference), prefetches data from an upstream stream into a small FIFO, and raises the accelerator's init/start handshake. It then supplies one data word on every accelerator write strobe and forwards the accelerator's result words to a downstream stream. It sits between the DMA/host fabric and the MLP core, so software sees one command port plus two data streams.

## Interface
Parameters:
- DataWidth, 16, width of weight/input/result words
- FifoDepth, 4, prefetch FIFO depth (power of two, ≥2)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset: one clock, synchronous, active-high
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_op_i  in  1  0 = Init (load weights), 1 = Run (inference)
- in_valid_i / in_ready_o  in/out  1  upstream data handshake
- in_data_i  in  DataWidth  upstream data word
- out_valid_o  out  1  result word valid (no back-pressure)
- out_data_o  out  DataWidth  result word
- done_o  out  1  one-cycle pulse at command completion
- err_o  out  1  sticky underrun flag
- err_clr_i  in  1  clears err_o
- init_valid_o / init_ready_i  out/in  1  accelerator init handshake
- start_valid_o / start_ready_i  out/in  1  accelerator start handshake
- result_valid_i  in  1  accelerator presents a result word this cycle
- w_wen_i  in  1  accelerator writes a weight this cycle
- x_wen_i  in  1  accelerator writes an activation this cycle
- x_sel_i  in  1  activation source; 0 = external input
- wdata_o  out  DataWidth  word for the current w_wen_i/x_wen_i strobe
- rdata_i  in  DataWidth  result word, valid with result_valid_i

## Operation
- Constants: WordsW = 2048 (8 layers × 256), WordsX = 256.
- States: Idle, Prefill, Req, Stream, Collect, Done.
- Idle: cmd_ready_o = 1. On accept, latch op and go to Prefill.
- Prefill: in_ready_o = !fifo_full. When the FIFO is full, go to Req.
- Req:
  - op Init: hold init_valid_o = 1 until init_ready_i.
  - op Run: hold start_valid_o = 1 until start_ready_i.
  - On handshake, clear the word counter and go to Stream.
- Stream:
  - Pop strobe: op Init uses w_wen_i; op Run uses x_wen_i && !x_sel_i.
  - in_ready_o = !fifo_full || pop; push and pop may occur in the same cycle.
  - wdata_o = FIFO head (show-ahead), valid in the same cycle as the strobe.
  - Each strobe increments the counter.
  - Strobe while the FIFO is empty: set err_o, drive wdata_o = 0, and still count the strobe.
  - Counter reaching WordsW (Init) → Done. Counter reaching WordsX (Run) → Collect.
- Collect:
  - in_ready_o = 0.
  - Each result_valid_i registers rdata_i to out_data_o and raises out_valid_o on the next cycle.
  - Downstream must accept every word; there is no back-pressure.
  - After WordsX results → Done.
- Done: done_o = 1 for one cycle, then Idle. Any remaining FIFO contents are flushed.
- err_o: set by underrun; cleared by err_clr_i; set wins when both occur in the same cycle.
- Strobes outside Stream are ignored. result_valid_i outside Collect is ignored.

## Timing
- Reset (rst_i high at a clock edge): state = Idle, FIFO emptied, counters = 0, err_o = 0.
- Output values while/after reset: cmd_ready_o = 1; all other outputs 0.
- Reset mid-command aborts immediately. The next cycle is Idle with no done_o pulse.
- Command accept → Prefill on the next edge.
- From an all-ready upstream, Prefill lasts FifoDepth cycles.
- init_valid_o / start_valid_o: asserted from the first Req cycle; deassert the cycle after the handshake.
- Result path latency: result_valid_i → out_valid_o is exactly 1 cycle.
- done_o timing:
  - Init: 1 cycle after the final counted strobe.
  - Run: 2 cycles after the final result_valid_i, i.e. the cycle after the last out_valid_o.
- Counter width: 12 bits, no wrap; the terminal compare uses count+1.
- cmd_valid_i while busy: not accepted (cmd_ready_o = 0), held upstream.

## Structure
- mlp_pkg (shared package):
  - op_e {OpInit, OpRun}
  - WordsW, WordsX
  - state enum
- Sub-module: mlp_sync_fifo.
  - Parameterised by DataWidth and FifoDepth.
  - Show-ahead head, full/empty flags.
  - Simultaneous push/pop legal when full.
  - Synchronous active-high clear.
- Top level holds the FSM, word counter, err flag and output register.

## Test plan
- Init, ideal upstream: accelerator model asserts w_wen_i for 2048 consecutive cycles after init_ready_i. Required: wdata_o sequence equals in_data_i sequence 0..2047, done_o once, err_o = 0.
- Run, end to end: 256 inputs then 256 result_valid_i with rdata_i = 0x100+i. Required: out_data_o = 0x100..0x1FF, each one cycle after its input, done_o the cycle after the last word.
- Underrun: upstream stalls after 10 words during Init. Required: strobe 11 gives wdata_o = 0 and err_o = 1; err_o stays set until err_clr_i; err_clr_i in the same cycle as a new underrun leaves err_o = 1.
- Handshake hold: init_ready_i held low for 5 cycles. Required: init_valid_o stays high 5 cycles, no pop, and cmd_valid_i is refused throughout.
- Reset mid-Stream at word 100. Required: next cycle cmd_ready_o = 1, FIFO empty, no done_o; a new Init completes correctly.
- Run ignoring x_sel_i = 1 strobes: interleave 50 internal writes. Required: only the 256 external strobes pop, and the counter reaches exactly 256.
